// File: rtl/apb_rr_master_pkg.sv
// Shared state encodings and slave indices for the two-requester APB master.
package apb_rr_master_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] SETUP  = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;

  // Value of the PADDR MSB that selects each slave
  localparam logic SLV1 = 1'b0;
  localparam logic SLV2 = 1'b1;

endpackage

// File: rtl/apb_rr_master_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie, the requester that did not win last time gets the grant.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (en) begin
      if (valid[0] && (!valid[1] || last_grant)) begin
        grant = 2'b01;
      end else if (valid[1]) begin
        grant = 2'b10;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB master shared by two requesters: round-robin accept, IDLE/SETUP/ACCESS sequencing,
// MSB address decode to two slaves, and a per-requester response with timeout abort.
module apb_rr_master
  import apb_rr_master_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 req0_valid,
  input  logic                 req0_write,
  input  logic [ADDRWIDTH-1:0] req0_addr,
  input  logic [DATAWIDTH-1:0] req0_wdata,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic                 req1_write,
  input  logic [ADDRWIDTH-1:0] req1_addr,
  input  logic [DATAWIDTH-1:0] req1_wdata,
  output logic                 req1_ready,
  output logic                 rsp0_valid,
  output logic [DATAWIDTH-1:0] rsp0_rdata,
  output logic                 rsp0_err,
  output logic                 rsp1_valid,
  output logic [DATAWIDTH-1:0] rsp1_rdata,
  output logic                 rsp1_err,
  output logic                 PSEL1,
  output logic                 PSEL2,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0] PWDATA,
  input  logic [DATAWIDTH-1:0] PRDATA1,
  input  logic [DATAWIDTH-1:0] PRDATA2,
  input  logic                 PREADY1,
  input  logic                 PREADY2
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [1:0]           state;
  logic                 last_grant;
  logic [CW-1:0]        wcnt;
  logic [1:0]           grant;
  logic                 hs;
  logic                 gid;
  logic                 win_write;
  logic [ADDRWIDTH-1:0] win_addr;
  logic [DATAWIDTH-1:0] win_wdata;
  logic                 pready;
  logic [DATAWIDTH-1:0] prdata;
  logic                 done;
  logic                 timeout_hit;
  logic [DATAWIDTH-1:0] done_rdata;

  rr_arbiter2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .en         ((state == IDLE) && !PRESET),
    .grant      (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign hs         = |grant;
  assign gid        = grant[1];

  always_comb begin
    win_write = gid ? req1_write : req0_write;
    win_addr  = gid ? req1_addr  : req0_addr;
    win_wdata = gid ? req1_wdata : req0_wdata;
  end

  // PADDR is the latched request address, so it doubles as the slave select for the mux
  always_comb begin
    pready = (PADDR[ADDRWIDTH-1] == SLV2) ? PREADY2 : PREADY1;
    prdata = (PADDR[ADDRWIDTH-1] == SLV2) ? PRDATA2 : PRDATA1;
  end

  assign timeout_hit = (wcnt == CW'(TIMEOUT - 1)) && !pready;
  assign done        = pready || timeout_hit;
  assign done_rdata  = (pready && !PWRITE) ? prdata : '0;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wcnt       <= '0;
      PSEL1      <= 1'b0;
      PSEL2      <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            last_grant <= gid;
            PWRITE     <= win_write;
            PADDR      <= win_addr;
            PWDATA     <= win_write ? win_wdata : '0;
            PSEL1      <= (win_addr[ADDRWIDTH-1] == SLV1);
            PSEL2      <= (win_addr[ADDRWIDTH-1] == SLV2);
            state      <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          wcnt    <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            PSEL1   <= 1'b0;
            PSEL2   <= 1'b0;
            PENABLE <= 1'b0;
            wcnt    <= '0;
            state   <= IDLE;
            // last_grant still names the owner of the transfer in flight
            if (last_grant) begin
              rsp1_valid <= 1'b1;
              rsp1_rdata <= done_rdata;
              rsp1_err   <= !pready;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_rdata <= done_rdata;
              rsp0_err   <= !pready;
            end
          end else if (wcnt != '1) begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench: two memory slaves (slave2 with programmable wait states) around apb_rr_master.
module tb_apb_rr_master;

  localparam int TMO = 16;

  typedef struct {
    int         id;
    int         cyc;
    logic [7:0] rdata;
    logic       err;
  } ev_t;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [1:0] rv;
  logic [1:0] rw;
  logic [7:0] ra [2];
  logic [7:0] rd [2];
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA1, PRDATA2;
  logic       PREADY1, PREADY2;

  logic [7:0] mem1 [128];
  logic [7:0] mem2 [128];
  int         stub_wait;
  int         waitc;

  int  cyc, p1cnt, p2cnt, acccnt, unstable, rdy_cyc;
  logic       pen_q, pwr_q;
  logic [7:0] paddr_q, pwdata_q;
  ev_t hsq[$];
  ev_t rspq[$];

  int n_cmp, n_bad;

  apb_rr_master #(.DATAWIDTH(8), .ADDRWIDTH(8), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(rv[0]), .req0_write(rw[0]), .req0_addr(ra[0]), .req0_wdata(rd[0]),
    .req0_ready(req0_ready),
    .req1_valid(rv[1]), .req1_write(rw[1]), .req1_addr(ra[1]), .req1_wdata(rd[1]),
    .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY1(PREADY1), .PREADY2(PREADY2)
  );

  always #5 PCLK = ~PCLK;

  // Slave1: zero-wait memory. Slave2: memory whose PREADY rises after stub_wait
  // ACCESS cycles (never when stub_wait < 0).
  assign PRDATA1 = mem1[PADDR[6:0]];
  assign PREADY1 = 1'b1;
  assign PRDATA2 = mem2[PADDR[6:0]];
  assign PREADY2 = PSEL2 && PENABLE && (stub_wait >= 0) && (waitc >= stub_wait);

  always @(posedge PCLK) begin
    if (PSEL1 && PENABLE && PREADY1 && PWRITE) mem1[PADDR[6:0]] <= PWDATA;
    if (PSEL2 && PENABLE && PREADY2 && PWRITE) mem2[PADDR[6:0]] <= PWDATA;
    if (PSEL2 && PENABLE) waitc <= waitc + 1;
    else                  waitc <= 0;
  end

  // Bus monitor, sampled on the falling edge
  initial begin
    cyc = 0; p1cnt = 0; p2cnt = 0; acccnt = 0; unstable = 0; rdy_cyc = -1;
    pen_q = 1'b0; pwr_q = 1'b0; paddr_q = '0; pwdata_q = '0;
  end

  always @(negedge PCLK) begin
    cyc <= cyc + 1;
    if (PSEL1)   p1cnt  <= p1cnt + 1;
    if (PSEL2)   p2cnt  <= p2cnt + 1;
    if (PENABLE) acccnt <= acccnt + 1;
    if (PENABLE && pen_q && (PADDR !== paddr_q || PWDATA !== pwdata_q || PWRITE !== pwr_q))
      unstable <= unstable + 1;
    if (PSEL2 && PENABLE && PREADY2) rdy_cyc <= cyc;
    pen_q <= PENABLE; pwr_q <= PWRITE; paddr_q <= PADDR; pwdata_q <= PWDATA;
    if (rv[0] && req0_ready) hsq.push_back('{id:0, cyc:cyc, rdata:8'h00, err:1'b0});
    if (rv[1] && req1_ready) hsq.push_back('{id:1, cyc:cyc, rdata:8'h00, err:1'b0});
    if (rsp0_valid) rspq.push_back('{id:0, cyc:cyc, rdata:rsp0_rdata, err:rsp0_err});
    if (rsp1_valid) rspq.push_back('{id:1, cyc:cyc, rdata:rsp1_rdata, err:rsp1_err});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer from requester n; returns its handshake and response records
  task automatic xfer(input int n, input logic wr, input logic [7:0] a, input logic [7:0] d,
                      output ev_t hs_e, output ev_t rs_e);
    int hb = hsq.size();
    int rb = rspq.size();
    hs_e = '{id:-1, cyc:0, rdata:8'h00, err:1'b0};
    rs_e = '{id:-1, cyc:0, rdata:8'h00, err:1'b0};
    rv[n] = 1'b1; rw[n] = wr; ra[n] = a; rd[n] = d;
    for (int c = 0; c < 60 && hsq.size() == hb; c++) begin
      @(posedge PCLK); #1;
    end
    rv[n] = 1'b0;
    check("handshake_seen", 32'(hsq.size() > hb), 32'd1);
    for (int c = 0; c < 100 && rspq.size() == rb; c++) begin
      @(posedge PCLK); #1;
    end
    check("rsp_seen", 32'(rspq.size() > rb), 32'd1);
    if (hsq.size() > hb)  hs_e = hsq[hb];
    if (rspq.size() > rb) rs_e = rspq[rb];
    check("rsp_id", 32'(rs_e.id), 32'(n));
  endtask

  // Both requesters hold valid until each has had n writes accepted
  task automatic both(input int n);
    int   left0 = n;
    int   left1 = n;
    int   rb = rspq.size();
    logic g0, g1;
    rv = 2'b11; rw = 2'b11;
    ra[0] = 8'h10; rd[0] = 8'h40;
    ra[1] = 8'h90; rd[1] = 8'h60;
    for (int c = 0; c < 400 && (left0 > 0 || left1 > 0); c++) begin
      @(negedge PCLK);
      g0 = req0_ready; g1 = req1_ready;
      @(posedge PCLK); #1;
      if (g0) begin
        left0--; ra[0]++; rd[0]++;
        if (left0 == 0) rv[0] = 1'b0;
      end
      if (g1) begin
        left1--; ra[1]++; rd[1]++;
        if (left1 == 0) rv[1] = 1'b0;
      end
    end
    rv = 2'b00;
    check("both_all_accepted", 32'(left0 + left1), 32'd0);
    for (int c = 0; c < 50 && rspq.size() < rb + 2 * n; c++) begin
      @(posedge PCLK); #1;
    end
    check("both_rsp_count", 32'(rspq.size() - rb), 32'(2 * n));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t h, r;
    int  b1, b2, ba, bu, hb, rb;
    n_cmp = 0; n_bad = 0;
    PRESET = 1'b1; rv = 2'b00; rw = 2'b00;
    ra[0] = '0; ra[1] = '0; rd[0] = '0; rd[1] = '0;
    stub_wait = 0;

    // Reset state
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_psel", {30'd0, PSEL1, PSEL2}, 32'd0);
    check("rst_penable_pwrite", {30'd0, PENABLE, PWRITE}, 32'd0);
    check("rst_paddr_pwdata", {16'd0, PADDR, PWDATA}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    check("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // 1: req0 write/read to slave1
    b1 = p1cnt; b2 = p2cnt;
    xfer(0, 1'b1, 8'h05, 8'hA5, h, r);
    check("t1_wr_psel1_cycles", 32'(p1cnt - b1), 32'd2);
    check("t1_wr_psel2_cycles", 32'(p2cnt - b2), 32'd0);
    check("t1_wr_latency", 32'(r.cyc - h.cyc), 32'd3);
    check("t1_wr_rdata", {24'd0, r.rdata}, 32'h00);
    check("t1_wr_err", {31'd0, r.err}, 32'd0);
    xfer(0, 1'b0, 8'h05, 8'h00, h, r);
    check("t1_rd_rdata", {24'd0, r.rdata}, 32'hA5);
    check("t1_rd_err", {31'd0, r.err}, 32'd0);

    // 2: req1 write/read to slave2, slave1 untouched
    b1 = p1cnt; b2 = p2cnt;
    xfer(1, 1'b1, 8'h85, 8'h3C, h, r);
    xfer(1, 1'b0, 8'h85, 8'h00, h, r);
    check("t2_rd_rdata", {24'd0, r.rdata}, 32'h3C);
    check("t2_psel1_cycles", 32'(p1cnt - b1), 32'd0);
    check("t2_psel2_cycles", 32'(p2cnt - b2), 32'd4);
    xfer(0, 1'b0, 8'h05, 8'h00, h, r);
    check("t2_slave1_untouched", {24'd0, r.rdata}, 32'hA5);

    // 4: timeout abort, then a normal transfer
    stub_wait = -1;
    ba = acccnt;
    xfer(1, 1'b0, 8'h90, 8'h00, h, r);
    check("t4_access_cycles", 32'(acccnt - ba), 32'(TMO));
    check("t4_err", {31'd0, r.err}, 32'd1);
    check("t4_rdata", {24'd0, r.rdata}, 32'h00);
    stub_wait = 0;
    xfer(1, 1'b0, 8'h85, 8'h00, h, r);
    check("t4_next_rdata", {24'd0, r.rdata}, 32'h3C);
    check("t4_next_err", {31'd0, r.err}, 32'd0);

    // 6: wait states with stable bus
    stub_wait = 3;
    ba = acccnt; bu = unstable;
    xfer(0, 1'b1, 8'h86, 8'h5A, h, r);
    check("t6_access_cycles", 32'(acccnt - ba), 32'd4);
    check("t6_bus_stable", 32'(unstable - bu), 32'd0);
    check("t6_rsp_after_ready", 32'(r.cyc - rdy_cyc), 32'd1);
    check("t6_err", {31'd0, r.err}, 32'd0);
    xfer(0, 1'b0, 8'h86, 8'h00, h, r);
    check("t6_readback", {24'd0, r.rdata}, 32'h5A);
    stub_wait = 0;

    // 3: alternation under continuous load from reset (last winner was req0)
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    hb = hsq.size();
    both(4);
    check("t3_hs_count", 32'(hsq.size() - hb), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (hb + i < hsq.size()) check("t3_grant_order", 32'(hsq[hb + i].id), 32'(i % 2));
    end

    // 5: reset during ACCESS (req0 owns the aborted transfer)
    stub_wait = -1;
    hb = hsq.size();
    rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 8'h90;
    for (int c = 0; c < 60 && hsq.size() == hb; c++) begin
      @(posedge PCLK); #1;
    end
    rv[0] = 1'b0;
    repeat (4) @(posedge PCLK);
    #1;
    check("t5_in_access", {31'd0, PENABLE}, 32'd1);
    rb = rspq.size();
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("t5_bus_idle", {29'd0, PSEL1, PSEL2, PENABLE}, 32'd0);
    PRESET = 1'b0;
    repeat (20) @(posedge PCLK);
    #1;
    check("t5_no_rsp", 32'(rspq.size() - rb), 32'd0);
    stub_wait = 0;
    hb = hsq.size();
    both(1);
    if (hsq.size() > hb) check("t5_first_grant", 32'(hsq[hb].id), 32'd0);
    else                 check("t5_first_grant_seen", 32'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
